// File: rtl/glb_strm_g2f_sched_pkg.sv
// Shared definitions for the GLB stream schedulers: default sizing
// constants, the G2F scheduler state type and the in-flight counter sizing.
package glb_pkg;

    localparam int G2F_CGRA_PER_GLB = 4;
    localparam int G2F_DATA_WIDTH   = 16;
    localparam int G2F_ADDR_WIDTH   = 19;
    localparam int G2F_LOOP_WIDTH   = 16;
    localparam int G2F_RD_LATENCY   = 2;
    localparam int G2F_LAT_WIDTH    = 8;

    typedef enum logic [1:0] {
        G2F_IDLE  = 2'd0,
        G2F_DELAY = 2'd1,
        G2F_RUN   = 2'd2,
        G2F_DRAIN = 2'd3
    } g2f_state_e;

    // Enough headroom for every read that can be outstanding between grant
    // and return, plus one spare bit so a same-cycle grant/return never wraps.
    function automatic int inflight_width(input int rd_latency);
        return $clog2(rd_latency + 1) + 1;
    endfunction

endpackage

// File: rtl/glb_strm_addr_gen.sv
// Two-level address walker: inner index i0 nested in outer index i1.
// Address is advanced with adders only (no multiply) and wraps modulo
// 2^ADDR_WIDTH. The pattern is latched on i_load; each i_step moves to the
// next point. o_last flags that the current point is the final one.
module glb_strm_addr_gen
    import glb_pkg::*;
#(
    parameter int ADDR_WIDTH = G2F_ADDR_WIDTH,
    parameter int LOOP_WIDTH = G2F_LOOP_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_load,
    input  logic [ADDR_WIDTH-1:0] i_start_addr,
    input  logic [ADDR_WIDTH-1:0] i_stride0,
    input  logic [ADDR_WIDTH-1:0] i_stride1,
    input  logic [LOOP_WIDTH-1:0] i_extent0,
    input  logic [LOOP_WIDTH-1:0] i_extent1,
    input  logic                  i_step,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_last
);

    logic [ADDR_WIDTH-1:0] r_stride0;
    logic [ADDR_WIDTH-1:0] r_stride1;
    logic [LOOP_WIDTH-1:0] r_ext0_m1;
    logic [LOOP_WIDTH-1:0] r_ext1_m1;
    logic [LOOP_WIDTH-1:0] r_i0;
    logic [LOOP_WIDTH-1:0] r_i1;
    logic [ADDR_WIDTH-1:0] r_row_base;
    logic [ADDR_WIDTH-1:0] r_addr;

    logic                  w_inner_last;
    logic                  w_outer_last;
    logic [ADDR_WIDTH-1:0] w_next_row;

    assign w_inner_last = (r_i0 == r_ext0_m1);
    assign w_outer_last = (r_i1 == r_ext1_m1);
    // Start of the next outer row; the row base keeps inner-loop steps from
    // having to be undone when the inner index wraps.
    assign w_next_row   = r_row_base + r_stride1;

    assign o_addr = r_addr;
    assign o_last = w_inner_last && w_outer_last;

    // Latch the pattern on load, then walk it one point per step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stride0  <= '0;
            r_stride1  <= '0;
            r_ext0_m1  <= '0;
            r_ext1_m1  <= '0;
            r_i0       <= '0;
            r_i1       <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
        end else if (i_load) begin
            r_stride0  <= i_stride0;
            r_stride1  <= i_stride1;
            r_ext0_m1  <= i_extent0 - LOOP_WIDTH'(1);
            r_ext1_m1  <= i_extent1 - LOOP_WIDTH'(1);
            r_i0       <= '0;
            r_i1       <= '0;
            r_row_base <= i_start_addr;
            r_addr     <= i_start_addr;
        end else if (i_step) begin
            if (w_inner_last) begin
                r_i0       <= '0;
                r_i1       <= r_i1 + LOOP_WIDTH'(1);
                r_row_base <= w_next_row;
                r_addr     <= w_next_row;
            end else begin
                r_i0   <= r_i0 + LOOP_WIDTH'(1);
                r_addr <= r_addr + r_stride0;
            end
        end
    end

endmodule

// File: rtl/glb_strm_g2f_sched.sv
// Per-tile GLB-to-fabric stream scheduler. A start pulse launches a walk of
// the configured two-level pattern, reads go to the bank arbiter, returned
// words are registered onto the enabled fabric lanes, and a one-cycle
// interrupt marks the cycle after the final word.
module glb_strm_g2f_sched
    import glb_pkg::*;
#(
    parameter int CGRA_PER_GLB    = G2F_CGRA_PER_GLB,
    parameter int CGRA_DATA_WIDTH = G2F_DATA_WIDTH,
    parameter int ADDR_WIDTH      = G2F_ADDR_WIDTH,
    parameter int LOOP_WIDTH      = G2F_LOOP_WIDTH,
    parameter int RD_LATENCY      = G2F_RD_LATENCY
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    cfg_en,
    input  logic [ADDR_WIDTH-1:0]                   cfg_start_addr,
    input  logic [ADDR_WIDTH-1:0]                   cfg_stride0,
    input  logic [ADDR_WIDTH-1:0]                   cfg_stride1,
    input  logic [LOOP_WIDTH-1:0]                   cfg_extent0,
    input  logic [LOOP_WIDTH-1:0]                   cfg_extent1,
    input  logic [7:0]                              cfg_start_latency,
    input  logic [CGRA_PER_GLB-1:0]                 cfg_lane_en,
    input  logic                                    strm_start_pulse,
    output logic                                    rd_req,
    output logic [ADDR_WIDTH-1:0]                   rd_addr,
    input  logic                                    rd_gnt,
    input  logic [CGRA_DATA_WIDTH-1:0]              rd_data,
    input  logic                                    rd_data_valid,
    output logic [CGRA_PER_GLB*CGRA_DATA_WIDTH-1:0] data_g2f,
    output logic [CGRA_PER_GLB-1:0]                 data_valid_g2f,
    output logic                                    strm_g2f_interrupt,
    output logic                                    busy
);

    localparam int INFL_W = inflight_width(RD_LATENCY);

    g2f_state_e                 r_state;
    g2f_state_e                 w_next_state;
    logic [7:0]                 r_dly_cnt;
    logic [CGRA_PER_GLB-1:0]    r_lane_en;
    logic [INFL_W-1:0]          r_infl;
    logic [CGRA_DATA_WIDTH-1:0] r_data;
    logic [CGRA_PER_GLB-1:0]    r_valid;
    logic                       r_irq;

    logic                       w_start;
    logic                       w_zero_ext;
    logic                       w_grant;
    logic                       w_accept;
    logic                       w_last;
    logic                       w_irq_set;
    logic [ADDR_WIDTH-1:0]      w_addr;

    assign w_start    = strm_start_pulse && cfg_en && (r_state == G2F_IDLE);
    assign w_zero_ext = (cfg_extent0 == '0) || (cfg_extent1 == '0);
    assign w_grant    = rd_req && rd_gnt;
    // Returns are only meaningful once this stream has issued reads; anything
    // arriving in IDLE/DELAY is left over from an aborted stream.
    assign w_accept   = rd_data_valid && ((r_state == G2F_RUN) || (r_state == G2F_DRAIN));

    assign rd_req             = (r_state == G2F_RUN);
    assign rd_addr            = w_addr;
    assign data_g2f           = {CGRA_PER_GLB{r_data}};
    assign data_valid_g2f     = r_valid;
    assign strm_g2f_interrupt = r_irq;
    assign busy               = (r_state != G2F_IDLE);

    glb_strm_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .LOOP_WIDTH (LOOP_WIDTH)
    ) u_addr_gen (
        .clk          (clk),
        .reset_n      (reset_n),
        .i_load       (w_start),
        .i_start_addr (cfg_start_addr),
        .i_stride0    (cfg_stride0),
        .i_stride1    (cfg_stride1),
        .i_extent0    (cfg_extent0),
        .i_extent1    (cfg_extent1),
        .i_step       (w_grant),
        .o_addr       (w_addr),
        .o_last       (w_last)
    );

    // State register plus the registered completion pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= G2F_IDLE;
            r_irq   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_irq   <= w_irq_set;
        end
    end

    // Next-state logic. A zero start latency skips DELAY so the first
    // request appears the cycle right after the pulse.
    always_comb begin
        w_next_state = r_state;
        w_irq_set    = 1'b0;
        case (r_state)
            G2F_IDLE: begin
                if (w_start) begin
                    if (w_zero_ext)
                        w_next_state = G2F_DRAIN;
                    else if (cfg_start_latency == 8'd0)
                        w_next_state = G2F_RUN;
                    else
                        w_next_state = G2F_DELAY;
                end
            end
            G2F_DELAY: begin
                if (r_dly_cnt == 8'd1)
                    w_next_state = G2F_RUN;
            end
            G2F_RUN: begin
                if (w_grant && w_last)
                    w_next_state = G2F_DRAIN;
            end
            G2F_DRAIN: begin
                // Counter reaching zero means the last word is being shown
                // on the output register this cycle; the pulse follows it.
                if (r_infl == '0) begin
                    w_next_state = G2F_IDLE;
                    w_irq_set    = 1'b1;
                end
            end
            default: w_next_state = G2F_IDLE;
        endcase
    end

    // Start-latency countdown and lane-enable shadow, captured at start.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_dly_cnt <= '0;
            r_lane_en <= '0;
        end else if (w_start) begin
            r_dly_cnt <= cfg_start_latency;
            r_lane_en <= cfg_lane_en;
        end else if (r_state == G2F_DELAY) begin
            r_dly_cnt <= r_dly_cnt - 8'd1;
        end
    end

    // Outstanding reads: +1 per grant, -1 per accepted return.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_infl <= '0;
        end else begin
            case ({w_grant, w_accept})
                2'b10:   r_infl <= r_infl + INFL_W'(1);
                2'b01:   r_infl <= r_infl - INFL_W'(1);
                default: r_infl <= r_infl;
            endcase
        end
    end

    // Output register: one word shared by all lanes, valid only on enabled lanes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data  <= '0;
            r_valid <= '0;
        end else begin
            r_valid <= {CGRA_PER_GLB{w_accept}} & r_lane_en;
            if (w_accept)
                r_data <= rd_data;
        end
    end

endmodule

// File: tb/tb_glb_strm_g2f_sched.sv
// Directed bench for glb_strm_g2f_sched with a fixed-latency bank model.
module tb_glb_strm_g2f_sched;

    localparam int NL = 4;
    localparam int DW = 16;
    localparam int AW = 19;
    localparam int LW = 16;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              cfg_en = 1'b0;
    logic [AW-1:0]     cfg_start_addr = '0;
    logic [AW-1:0]     cfg_stride0 = '0;
    logic [AW-1:0]     cfg_stride1 = '0;
    logic [LW-1:0]     cfg_extent0 = '0;
    logic [LW-1:0]     cfg_extent1 = '0;
    logic [7:0]        cfg_start_latency = '0;
    logic [NL-1:0]     cfg_lane_en = '0;
    logic              strm_start_pulse = 1'b0;
    logic              rd_req;
    logic [AW-1:0]     rd_addr;
    logic              rd_gnt = 1'b0;
    logic [DW-1:0]     rd_data = '0;
    logic              rd_data_valid = 1'b0;
    logic [NL*DW-1:0]  data_g2f;
    logic [NL-1:0]     data_valid_g2f;
    logic              strm_g2f_interrupt;
    logic              busy;

    glb_strm_g2f_sched dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .cfg_en             (cfg_en),
        .cfg_start_addr     (cfg_start_addr),
        .cfg_stride0        (cfg_stride0),
        .cfg_stride1        (cfg_stride1),
        .cfg_extent0        (cfg_extent0),
        .cfg_extent1        (cfg_extent1),
        .cfg_start_latency  (cfg_start_latency),
        .cfg_lane_en        (cfg_lane_en),
        .strm_start_pulse   (strm_start_pulse),
        .rd_req             (rd_req),
        .rd_addr            (rd_addr),
        .rd_gnt             (rd_gnt),
        .rd_data            (rd_data),
        .rd_data_valid      (rd_data_valid),
        .data_g2f           (data_g2f),
        .data_valid_g2f     (data_valid_g2f),
        .strm_g2f_interrupt (strm_g2f_interrupt),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    // Bank content: each address holds its low 16 bits plus 0x1000.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a[DW-1:0] + 16'h1000;
    endfunction

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Bank model: word returned exactly two cycles after its grant.
    logic          g_s = 1'b0;
    logic [AW-1:0] a_s = '0;
    logic          m_v = 1'b0;
    logic [AW-1:0] m_a = '0;
    always @(posedge clk) begin
        g_s = rd_req && rd_gnt;
        a_s = rd_addr;
        #1;
        rd_data_valid = m_v;
        rd_data       = mem_word(m_a);
        m_v = g_s;
        m_a = a_s;
    end

    // Observation log, sampled mid-cycle.
    logic [AW-1:0]    q_gaddr[$];
    int               q_gcyc[$];
    logic [NL*DW-1:0] q_vdata[$];
    logic [NL-1:0]    q_vmask[$];
    int               q_vcyc[$];
    int               irq_cnt = 0;
    int               irq_cyc = -1;
    logic             busy_at_irq = 1'b1;
    always @(negedge clk) begin
        if (rd_req && rd_gnt) begin
            q_gaddr.push_back(rd_addr);
            q_gcyc.push_back(cyc);
        end
        if (data_valid_g2f != '0) begin
            q_vdata.push_back(data_g2f);
            q_vmask.push_back(data_valid_g2f);
            q_vcyc.push_back(cyc);
        end
        if (strm_g2f_interrupt) begin
            irq_cnt++;
            irq_cyc = cyc;
            busy_at_irq = busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end");
        $fatal(1);
    end

    int checks = 0;
    int errors = 0;
    logic [AW-1:0] exp_a [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse for one cycle; t is the cycle in which the pulse is high.
    task automatic start(output int t);
        @(posedge clk);
        #1 strm_start_pulse = 1'b1;
        @(negedge clk);
        t = cyc;
        @(posedge clk);
        #1 strm_start_pulse = 1'b0;
    endtask

    task automatic wait_irq(input string tg, input int ic0, input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (irq_cnt > ic0) seen = 1'b1;
        end
        @(negedge clk);
        chk({tg, "_timeout"}, 64'(seen), 64'd1);
    endtask

    task automatic check_stream(input string tg, input int n, input int ga0,
                                input int v0, input logic [NL-1:0] mask);
        chk({tg, "_ngrant"}, 64'(q_gaddr.size() - ga0), 64'(n));
        chk({tg, "_nvalid"}, 64'(q_vdata.size() - v0), 64'(n));
        for (int i = 0; i < n; i++) begin
            chk({tg, "_addr"}, 64'(q_gaddr[ga0 + i]), 64'(exp_a[i]));
            chk({tg, "_data"}, q_vdata[v0 + i], {NL{mem_word(exp_a[i])}});
            chk({tg, "_mask"}, 64'(q_vmask[v0 + i]), 64'(mask));
        end
    endtask

    int t, ga0, v0, ic0, idx;
    logic [15:0] pat;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_req", 64'(rd_req), 64'd0);
        chk("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk("rst_data", data_g2f, 64'd0);
        chk("rst_valid", 64'(data_valid_g2f), 64'd0);
        chk("rst_irq", 64'(strm_g2f_interrupt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        cfg_en  = 1'b1;

        // 1-D, latency 0, grant always high
        cfg_start_addr = 19'h100; cfg_stride0 = 19'd2; cfg_stride1 = 19'd0;
        cfg_extent0 = 16'd4; cfg_extent1 = 16'd1; cfg_start_latency = 8'd0;
        cfg_lane_en = 4'hF; rd_gnt = 1'b1;
        exp_a[0] = 19'h100; exp_a[1] = 19'h102; exp_a[2] = 19'h104; exp_a[3] = 19'h106;
        ga0 = q_gaddr.size(); v0 = q_vdata.size(); ic0 = irq_cnt;
        start(t);
        @(negedge clk);
        chk("t1_busy_t1", 64'(busy), 64'd1);
        chk("t1_req_t1", 64'(rd_req), 64'd1);
        wait_irq("t1", ic0, 40);
        check_stream("t1", 4, ga0, v0, 4'hF);
        chk("t1_first_gnt_cyc", 64'(q_gcyc[ga0]), 64'(t + 1));
        chk("t1_last_gnt_cyc", 64'(q_gcyc[ga0 + 3]), 64'(t + 4));
        chk("t1_first_valid_cyc", 64'(q_vcyc[v0]), 64'(t + 4));
        chk("t1_last_valid_cyc", 64'(q_vcyc[v0 + 3]), 64'(t + 7));
        chk("t1_irq_cyc", 64'(irq_cyc), 64'(t + 8));
        chk("t1_busy_at_irq", 64'(busy_at_irq), 64'd0);
        chk("t1_irq_count", 64'(irq_cnt - ic0), 64'd1);

        // 2-D, latency 3, two lanes enabled
        cfg_start_addr = 19'h0; cfg_stride0 = 19'd2; cfg_stride1 = 19'h40;
        cfg_extent0 = 16'd3; cfg_extent1 = 16'd2; cfg_start_latency = 8'd3;
        cfg_lane_en = 4'b0101;
        exp_a[0] = 19'h0;  exp_a[1] = 19'h2;  exp_a[2] = 19'h4;
        exp_a[3] = 19'h40; exp_a[4] = 19'h42; exp_a[5] = 19'h44;
        ga0 = q_gaddr.size(); v0 = q_vdata.size(); ic0 = irq_cnt;
        start(t);
        @(negedge clk);
        chk("t2_req_t1", 64'(rd_req), 64'd0);
        wait_irq("t2", ic0, 40);
        check_stream("t2", 6, ga0, v0, 4'b0101);
        chk("t2_first_gnt_cyc", 64'(q_gcyc[ga0]), 64'(t + 4));
        chk("t2_irq_cyc", 64'(irq_cyc), 64'(q_vcyc[v0 + 5] + 1));

        // 2-D with grant stalls, latency 1
        cfg_start_addr = 19'h200; cfg_start_latency = 8'd1; cfg_lane_en = 4'hF;
        exp_a[0] = 19'h200; exp_a[1] = 19'h202; exp_a[2] = 19'h204;
        exp_a[3] = 19'h240; exp_a[4] = 19'h242; exp_a[5] = 19'h244;
        rd_gnt = 1'b0;
        pat = 16'hA5C3;
        idx = 0;
        ga0 = q_gaddr.size(); v0 = q_vdata.size(); ic0 = irq_cnt;
        start(t);
        for (int k = 0; k < 80 && irq_cnt == ic0; k++) begin
            @(posedge clk);
            #1 rd_gnt = pat[k % 16];
            @(negedge clk);
            if (rd_req) begin
                if (idx < 6) chk("t3_addr_hold", 64'(rd_addr), 64'(exp_a[idx]));
                else chk("t3_extra_req", 64'(rd_req), 64'd0);
                if (rd_gnt) idx++;
            end
        end
        rd_gnt = 1'b1;
        wait_irq("t3", ic0, 20);
        check_stream("t3", 6, ga0, v0, 4'hF);
        chk("t3_irq_count", 64'(irq_cnt - ic0), 64'd1);

        // Zero extent, plus a second pulse while busy
        cfg_extent0 = 16'd0; cfg_extent1 = 16'd2; cfg_start_latency = 8'd0;
        ga0 = q_gaddr.size(); v0 = q_vdata.size(); ic0 = irq_cnt;
        start(t);
        strm_start_pulse = 1'b1;
        @(posedge clk);
        #1 strm_start_pulse = 1'b0;
        repeat (10) @(negedge clk);
        chk("t4_irq_count", 64'(irq_cnt - ic0), 64'd1);
        chk("t4_irq_cyc", 64'(irq_cyc), 64'(t + 2));
        chk("t4_no_grant", 64'(q_gaddr.size() - ga0), 64'd0);
        chk("t4_no_valid", 64'(q_vdata.size() - v0), 64'd0);
        chk("t4_busy", 64'(busy), 64'd0);

        // Address wrap
        cfg_start_addr = 19'h7FFFE; cfg_stride0 = 19'd1; cfg_stride1 = 19'd0;
        cfg_extent0 = 16'd4; cfg_extent1 = 16'd1;
        exp_a[0] = 19'h7FFFE; exp_a[1] = 19'h7FFFF; exp_a[2] = 19'h00000; exp_a[3] = 19'h00001;
        ga0 = q_gaddr.size(); v0 = q_vdata.size(); ic0 = irq_cnt;
        start(t);
        wait_irq("t5", ic0, 40);
        check_stream("t5", 4, ga0, v0, 4'hF);

        // Reset mid-RUN with two reads in flight
        cfg_start_addr = 19'h300; cfg_extent0 = 16'd8;
        ga0 = q_gaddr.size(); ic0 = irq_cnt;
        start(t);
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b0;
        @(negedge clk);
        chk("t6_grants_before", 64'(q_gaddr.size() - ga0), 64'd4);
        chk("t6_rd_req", 64'(rd_req), 64'd0);
        chk("t6_rd_addr", 64'(rd_addr), 64'd0);
        chk("t6_data", data_g2f, 64'd0);
        chk("t6_valid", 64'(data_valid_g2f), 64'd0);
        chk("t6_busy", 64'(busy), 64'd0);
        reset_n = 1'b1;
        v0 = q_vdata.size();
        repeat (8) @(negedge clk);
        chk("t6_no_late_valid", 64'(q_vdata.size() - v0), 64'd0);
        chk("t6_no_irq", 64'(irq_cnt - ic0), 64'd0);
        chk("t6_idle", 64'(busy), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
